array_to_mem: RTL and testbench
===============================

ARRAY_TO_MEM -- requirements
Module: array_to_mem

Interface
REQ-001 Parameter MAX_BLOCK_NUM, default 32, number of 64-word block slots in the destination memory; address wraps modulo this value.
REQ-002 Parameter MAX_PIXEL_NUM, default 64, words per 8x8 block; fixed at 64, any other value is unsupported.
REQ-003 clock  input  1  sole clock; all state updates on posedge clock.
REQ-004 reset_n  input  1  asynchronous, active-low reset (0 reset, 1 not reset).
REQ-005 start  input  1  request to capture input_data_array and write it out; sampled only in IDLE.
REQ-006 block_index  input  32  destination block number, latched with start.
REQ-007 input_data_array  input  32 x [8][8]  coefficient block, row j, column k.
REQ-008 mem_ready  input  1  memory accepts the current word when high together with mem_we.
REQ-009 mem_we  output  1  write request; current mem_addr/mem_wdata valid.
REQ-010 mem_addr  output  32  word address of the current write.
REQ-011 mem_wdata  output  32  data of the current write.
REQ-012 busy  output  1  high from the cycle after accepted start until done is asserted.
REQ-013 done  output  1  one-cycle pulse after the 64th word is accepted.

Function
REQ-014 FSM states IDLE, WRITE, DONE; all outputs are registered.
REQ-015 IDLE: on start=1, capture all 64 words of input_data_array into an internal buffer, latch base = (block_index % MAX_BLOCK_NUM) * 64, set index=0, go to WRITE.
REQ-016 WRITE: mem_we=1, mem_addr=base+index, mem_wdata=buffer[index/8][index%8] (raster order, row-major).
REQ-017 A word is transferred in a cycle where mem_we=1 and mem_ready=1; index then increments by 1.
REQ-018 While mem_we=1 and mem_ready=0, mem_addr and mem_wdata remain unchanged.
REQ-019 When the word at index 63 is transferred, mem_we drops next cycle and FSM goes to DONE.
REQ-020 DONE: done=1 and busy=0 for exactly one cycle, then unconditional return to IDLE.
REQ-021 start is ignored in WRITE and DONE; changes to input_data_array or block_index after capture have no effect on the transfer in progress.
REQ-022 Latency: mem_we first high in the cycle after start is sampled; with mem_ready held high, done pulses 65 cycles after start is sampled.
REQ-023 block_index >= MAX_BLOCK_NUM wraps (e.g. 33 with default maps to base 64); address arithmetic is 32-bit unsigned, no overflow checks.
REQ-024 index is a 6-bit counter; no wrap-around beyond 63 occurs because the FSM leaves WRITE on the 64th transfer.

Reset
REQ-025 reset_n=0 forces immediately, independent of clock: state IDLE, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, index=0, buffer all zero.
REQ-026 Reset asserted mid-transfer aborts the block; no further writes occur and no done pulse is produced.
REQ-027 After reset_n rises, the first accepted start behaves exactly as from power-up.

Structure
REQ-028 MAX_BLOCK_NUM and MAX_PIXEL_NUM defaults come from the shared prores_param definitions; the FSM state enum is local to the module.
REQ-029 Single module; no sub-module is natural (buffer, counter and FSM are each too small to separate).

Verification
REQ-030 Array word[j][k]=j*8+k+1, block_index=2, start pulse, mem_ready=1 -> 64 writes addr 128..191, data 1..64 in order, done pulse 65 cycles after start.
REQ-031 Same block, mem_ready toggled 1,0,1,0... -> 64 writes, no duplicated or skipped address, addr/data stable across every low-ready cycle, done after 128 write cycles.
REQ-032 block_index=33 (MAX_BLOCK_NUM=32) -> addresses 64..127.
REQ-033 start re-pulsed and input_data_array changed to all 0xFFFF_FFFF during WRITE -> ignored; original data written, single done pulse.
REQ-034 reset_n pulsed low after 10 transfers -> mem_we=0 and all outputs zero in the same cycle, no done; new start afterwards writes a full block from index 0.
REQ-035 Back-to-back: start held high continuously -> a second block starts the cycle after DONE returns to IDLE, one idle cycle between done and next mem_we.

Source files
------------

// File: rtl/array_to_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : array_to_mem_pkg                                               |
// | Description : Shared definitions for the block-to-memory writer: default    |
// |               geometry parameters, the 8x8 coefficient block type and a     |
// |               raster-order word selector.                                   |
// | Revision    : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
package array_to_mem_pkg;

  // Default geometry shared with the rest of the codec.
  localparam int DEF_MAX_BLOCK_NUM = 32;
  localparam int DEF_MAX_PIXEL_NUM = 64;

  // One 8x8 block of 32-bit coefficients, indexed [row][column].
  typedef logic [7:0][7:0][31:0] block_t;

  // Word at raster position idx: row = idx/8, column = idx%8.
  function automatic logic [31:0] raster_word(input block_t blk, input logic [5:0] idx);
    return blk[idx[5:3]][idx[2:0]];
  endfunction

endpackage : array_to_mem_pkg
`default_nettype wire

// File: rtl/array_to_mem_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : array_to_mem_if                                                |
// | Description : Request and memory-write bus of the block writer.             |
// |   start, block_index, input_data_array : request side (master -> slave)     |
// |   mem_ready                            : memory back-pressure (-> slave)    |
// |   mem_we, mem_addr, mem_wdata          : memory write port (slave ->)       |
// |   busy, done                           : status (slave ->)                  |
// | Revision    : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
interface array_to_mem_if;
  import array_to_mem_pkg::*;

  logic        start;
  logic [31:0] block_index;
  block_t      input_data_array;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;

  // Requester / memory side.
  modport master (
    output start, block_index, input_data_array, mem_ready,
    input  mem_we, mem_addr, mem_wdata, busy, done
  );

  // Block writer side.
  modport slave (
    input  start, block_index, input_data_array, mem_ready,
    output mem_we, mem_addr, mem_wdata, busy, done
  );

endinterface : array_to_mem_if
`default_nettype wire

// File: rtl/array_to_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : array_to_mem                                                   |
// | Description : Captures an 8x8 coefficient block on start and writes its 64   |
// |               words in raster order to block slot                           |
// |               (block_index % MAX_BLOCK_NUM) of a word-addressed memory,     |
// |               honouring mem_ready back-pressure. All outputs registered.    |
// | Ports       : clock    - sole clock, rising edge                            |
// |               reset_n  - asynchronous active-low reset                      |
// |               bus      - array_to_mem_if.slave (request, write, status)     |
// | Revision    : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module array_to_mem
  import array_to_mem_pkg::*;
#(
  parameter int MAX_BLOCK_NUM = DEF_MAX_BLOCK_NUM,
  parameter int MAX_PIXEL_NUM = DEF_MAX_PIXEL_NUM   // must be 64
) (
  input  logic          clock,
  input  logic          reset_n,
  array_to_mem_if.slave bus
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_WRITE = 2'd1;
  localparam logic [1:0] c_DONE  = 2'd2;

  localparam logic [5:0] c_LAST_IDX = 6'd63;

  logic [1:0]  state_q,     state_d;
  block_t      buffer_q,    buffer_d;
  logic [31:0] base_q,      base_d;
  logic [5:0]  index_q,     index_d;
  logic        mem_we_q,    mem_we_d;
  logic [31:0] mem_addr_q,  mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        busy_q,      busy_d;
  logic        done_q,      done_d;

  logic        w_xfer;
  logic [5:0]  w_idx_nxt;
  logic [31:0] w_base;

  assign w_xfer    = mem_we_q & bus.mem_ready;
  assign w_idx_nxt = index_q + 6'd1;
  assign w_base    = (bus.block_index % 32'(MAX_BLOCK_NUM)) * 32'(MAX_PIXEL_NUM);

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= c_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE:  if (bus.start) state_d = c_WRITE;
      c_WRITE: if (w_xfer && (index_q == c_LAST_IDX)) state_d = c_DONE;
      c_DONE:  state_d = c_IDLE;
      default: state_d = c_IDLE;
    endcase
  end

  // ------------------------------------------------------ output / datapath
  always_comb begin
    buffer_d    = buffer_q;
    base_d      = base_q;
    index_d     = index_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      c_IDLE: begin
        if (bus.start) begin
          buffer_d    = bus.input_data_array;
          base_d      = w_base;
          index_d     = 6'd0;
          mem_we_d    = 1'b1;
          mem_addr_d  = w_base;
          // The buffer is loaded on this same edge, so word 0 comes
          // straight from the input array.
          mem_wdata_d = raster_word(bus.input_data_array, 6'd0);
          busy_d      = 1'b1;
        end
      end
      c_WRITE: begin
        if (w_xfer) begin
          if (index_q == c_LAST_IDX) begin
            mem_we_d = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
          end else begin
            index_d     = w_idx_nxt;
            mem_addr_d  = base_q + {26'd0, w_idx_nxt};
            mem_wdata_d = raster_word(buffer_q, w_idx_nxt);
          end
        end
      end
      c_DONE: begin
        mem_we_d = 1'b0;
        busy_d   = 1'b0;
      end
      default: begin
        mem_we_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      buffer_q    <= '0;
      base_q      <= '0;
      index_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      buffer_q    <= buffer_d;
      base_q      <= base_d;
      index_q     <= index_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule : array_to_mem
`default_nettype wire

// File: tb/tb_array_to_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_array_to_mem                                                |
// | Description : Directed self-checking bench for array_to_mem.                |
// | Revision    : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module tb_array_to_mem;
  import array_to_mem_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  array_to_mem_if bus();

  array_to_mem #(
    .MAX_BLOCK_NUM (32),
    .MAX_PIXEL_NUM (64)
  ) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  int     n_vec  = 0;
  int     n_miss = 0;
  block_t exp_blk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pattern 0: word[j][k] = j*8+k+1.  Pattern 1: 0xA5000000 + 7*(j*8+k).
  task automatic load(input int pat);
    for (int j = 0; j < 8; j++) begin
      for (int k = 0; k < 8; k++) begin
        if (pat == 0) exp_blk[j][k] = 32'(j * 8 + k + 1);
        else          exp_blk[j][k] = 32'hA500_0000 + 32'((j * 8 + k) * 7);
      end
    end
    bus.input_data_array = exp_blk;
  endtask

  // Called in cycle 1 after start was sampled. Follows the block to its done
  // cycle and checks every write and the done-cycle position.
  task automatic xfer(input logic [31:0] base, input bit toggle, input bit disturb,
                      input int exp_done);
    int         c;
    int         k;
    logic       rdy;
    logic [5:0] ki;
    c = 1;
    k = 0;
    while (c <= 300 && bus.done !== 1'b1) begin
      rdy = toggle ? c[0] : 1'b1;
      bus.mem_ready = rdy;
      chk("mem_we_active", {31'd0, bus.mem_we}, 32'd1);
      chk("busy_active", {31'd0, bus.busy}, 32'd1);
      if (bus.mem_we === 1'b1) begin
        if (k < 64) begin
          ki = 6'(k);
          chk("mem_addr", bus.mem_addr, base + 32'(k));
          chk("mem_wdata", bus.mem_wdata, exp_blk[ki[5:3]][ki[2:0]]);
        end else begin
          chk("extra_write", 32'(k), 32'd63);
        end
        if (rdy) k++;
      end
      if (disturb && c == 5) begin
        bus.start            = 1'b1;
        bus.block_index      = 32'd7;
        bus.input_data_array = '1;
      end
      if (disturb && c == 9) bus.start = 1'b0;
      tick();
      c++;
    end
    chk("done_cycle", 32'(c), 32'(exp_done));
    chk("word_count", 32'(k), 32'd64);
    chk("done_pulse", {31'd0, bus.done}, 32'd1);
    chk("busy_at_done", {31'd0, bus.busy}, 32'd0);
    chk("we_at_done", {31'd0, bus.mem_we}, 32'd0);
    bus.mem_ready = 1'b1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_we"}, {31'd0, bus.mem_we}, 32'd0);
    chk({tag, "_done"}, {31'd0, bus.done}, 32'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_we"}, {31'd0, bus.mem_we}, 32'd0);
    chk({tag, "_addr"}, bus.mem_addr, 32'd0);
    chk({tag, "_wdata"}, bus.mem_wdata, 32'd0);
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start            = 1'b0;
    bus.block_index      = 32'd0;
    bus.input_data_array = '0;
    bus.mem_ready        = 1'b1;

    // Reset state
    #1 rst_n = 1'b0;
    #1 check_zero("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_zero("post_reset");

    // Basic block, mem_ready high: addr 128..191, data 1..64, done at cycle 65
    load(0);
    bus.block_index = 32'd2;
    bus.start       = 1'b1;
    tick();
    bus.start = 1'b0;
    xfer(32'd128, 1'b0, 1'b0, 65);
    tick();
    check_idle("after_done");

    // Same block, mem_ready toggling 1,0,1,0...: done at cycle 128
    load(0);
    bus.block_index = 32'd2;
    bus.start       = 1'b1;
    tick();
    bus.start = 1'b0;
    xfer(32'd128, 1'b1, 1'b0, 128);
    tick();
    check_idle("after_toggle");

    // Wrap: block 33 -> base 64
    load(1);
    bus.block_index = 32'd33;
    bus.start       = 1'b1;
    tick();
    bus.start = 1'b0;
    xfer(32'd64, 1'b0, 1'b0, 65);
    tick();
    check_idle("after_wrap");

    // start and data disturbed during WRITE: ignored, single done
    load(0);
    bus.block_index = 32'd5;
    bus.start       = 1'b1;
    tick();
    bus.start = 1'b0;
    xfer(32'd320, 1'b0, 1'b1, 65);
    tick();
    check_idle("disturb_1");
    tick();
    check_idle("disturb_2");
    tick();
    check_idle("disturb_3");

    // Reset after 10 transfers: outputs clear immediately, no done
    load(1);
    bus.block_index = 32'd3;
    bus.start       = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (10) tick();
    chk("pre_reset_addr", bus.mem_addr, 32'd202);
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset");
    tick();
    tick();
    check_zero("held_reset");
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      check_idle("after_abort");
    end
    load(0);
    bus.block_index = 32'd0;
    bus.start       = 1'b1;
    tick();
    bus.start = 1'b0;
    xfer(32'd0, 1'b0, 1'b0, 65);
    tick();
    check_idle("after_restart");

    // Back-to-back with start held high: one idle cycle between blocks
    load(1);
    bus.block_index = 32'd1;
    bus.start       = 1'b1;
    tick();
    xfer(32'd64, 1'b0, 1'b0, 65);
    tick();
    check_idle("b2b_gap");
    tick();
    chk("b2b_second_we", {31'd0, bus.mem_we}, 32'd1);
    chk("b2b_second_addr", bus.mem_addr, 32'd64);
    bus.start = 1'b0;
    xfer(32'd64, 1'b0, 1'b0, 65);
    tick();
    check_idle("b2b_end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_array_to_mem
`default_nettype wire
